// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
//   ID/EX pipeline register of the 5-stage CPU. It captures the register-file
//   read data, immediate, PC, register addresses and decoded control into the
//   EX stage. Because the RF write lands on the clock edge, it applies a
//   WB->ID bypass on the operands. It also detects load-use hazards, inserts
//   one bubble per hazard, and honours flush (EX redirect) and hold (EX busy).
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   id_*                     ID-stage instruction fields and RF read data
//   wb_wr, wb_rd, wb_data    RF write port of the WB stage (bypass source)
//   ex_flush                 kill the ID instruction (taken branch/jump in EX)
//   ex_busy                  EX cannot accept; hold this register
//   stall_id                 IF/ID must hold this cycle
//   ex_*                     registered EX-stage fields
//   bubble_cnt               saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_pipe #(
  parameter int CTRL_W = 16,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rd,
  input  logic              id_rd_wr,
  input  logic              id_mem_rd,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_wr,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  input  logic              ex_busy,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic              ex_rd_wr,
  output logic              ex_mem_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              valid_q,  valid_d;
  logic [XLEN-1:0]   pc_q,     pc_d;
  logic [XLEN-1:0]   imm_q,    imm_d;
  logic [XLEN-1:0]   op1_q,    op1_d;
  logic [XLEN-1:0]   op2_q,    op2_d;
  logic [4:0]        rs1_q,    rs1_d;
  logic [4:0]        rs2_q,    rs2_d;
  logic [4:0]        rd_q,     rd_d;
  logic              rd_wr_q,  rd_wr_d;
  logic              mem_rd_q, mem_rd_d;
  logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;

  logic [XLEN-1:0]   op1, op2;
  logic              lu;

  // WB->ID bypass; x0 is never forwarded so it always reads the RF zero.
  assign op1 = (wb_wr && (wb_rd != 5'd0) && (wb_rd == id_rs1)) ? wb_data : id_rs1_data;
  assign op2 = (wb_wr && (wb_rd != 5'd0) && (wb_rd == id_rs2)) ? wb_data : id_rs2_data;

  // Load in EX whose result a real ID instruction needs right now.
  assign lu = valid_q && mem_rd_q && (rd_q != 5'd0) && id_valid &&
              ((id_rs1_used && (id_rs1 == rd_q)) || (id_rs2_used && (id_rs2 == rd_q)));

  // A flushed ID instruction is being killed, so a hazard on it need not stall.
  assign stall_id = ex_busy || (lu && !ex_flush);

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    imm_d    = imm_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rd_d     = rd_q;
    rd_wr_d  = rd_wr_q;
    mem_rd_d = mem_rd_q;
    ctrl_d   = ctrl_q;
    cnt_d    = cnt_q;
    if (ex_flush) begin
      // Flush wins over busy: the redirecting instruction already sits in EX
      // and completes there; only the slot behind it becomes a bubble.
      valid_d  = 1'b0;
      rd_wr_d  = 1'b0;
      mem_rd_d = 1'b0;
      ctrl_d   = '0;
    end else if (!ex_busy) begin
      if (lu) begin
        // Data fields keep their previous values in a bubble.
        valid_d  = 1'b0;
        rd_wr_d  = 1'b0;
        mem_rd_d = 1'b0;
        ctrl_d   = '0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        valid_d  = id_valid;
        pc_d     = id_pc;
        imm_d    = id_imm;
        op1_d    = op1;
        op2_d    = op2;
        rs1_d    = id_rs1;
        rs2_d    = id_rs2;
        rd_d     = id_rd;
        rd_wr_d  = id_valid && id_rd_wr;
        mem_rd_d = id_valid && id_mem_rd;
        ctrl_d   = id_valid ? id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      rd_wr_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      ctrl_q   <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      imm_q    <= imm_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      rd_wr_q  <= rd_wr_d;
      mem_rd_q <= mem_rd_d;
      ctrl_q   <= ctrl_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ex_valid    = valid_q;
  assign ex_pc       = pc_q;
  assign ex_imm      = imm_q;
  assign ex_rs1_data = op1_q;
  assign ex_rs2_data = op2_q;
  assign ex_rs1      = rs1_q;
  assign ex_rs2      = rs2_q;
  assign ex_rd       = rd_q;
  assign ex_rd_wr    = rd_wr_q;
  assign ex_mem_rd   = mem_rd_q;
  assign ex_ctrl     = ctrl_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe
//   Directed, table-driven bench for id_ex_pipe (CNT_W=2 so saturation is
//   reachable). Each table row is applied for one clock; stall_id is checked
//   before the edge, the ex_* outputs 1 time unit after it. Hand-written
//   sequences cover asynchronous reset and counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_rs1_used, id_rs2_used;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rd;
  logic        id_rd_wr, id_mem_rd;
  logic [15:0] id_ctrl;
  logic        wb_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_flush, ex_busy;
  logic        stall_id, ex_valid;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_rd_wr, ex_mem_rd;
  logic [15:0] ex_ctrl;
  logic [1:0]  bubble_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_pipe #(.CTRL_W(16), .XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rd(id_rd), .id_rd_wr(id_rd_wr),
    .id_mem_rd(id_mem_rd), .id_ctrl(id_ctrl),
    .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_busy(ex_busy),
    .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd_wr(ex_rd_wr), .ex_mem_rd(ex_mem_rd),
    .ex_ctrl(ex_ctrl), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic        u1;
    logic [31:0] d1;
    logic [4:0]  rs2;
    logic        u2;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rdwr;
    logic        memrd;
    logic [15:0] ctrl;
    logic        wbwr;
    logic [4:0]  wbrd;
    logic [31:0] wbdata;
    logic        flush;
    logic        busy;
  } in_t;

  typedef struct {
    logic        stall;
    logic        vld;
    logic        chk;   // compare data/address fields (not for bubbles)
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rdwr;
    logic        memrd;
    logic [15:0] ctrl;
    logic [1:0]  cnt;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input in_t i);
    id_valid    = i.vld;   id_pc       = i.pc;
    id_rs1      = i.rs1;   id_rs1_used = i.u1;  id_rs1_data = i.d1;
    id_rs2      = i.rs2;   id_rs2_used = i.u2;  id_rs2_data = i.d2;
    id_imm      = i.imm;   id_rd       = i.rd;
    id_rd_wr    = i.rdwr;  id_mem_rd   = i.memrd; id_ctrl   = i.ctrl;
    wb_wr       = i.wbwr;  wb_rd       = i.wbrd;  wb_data   = i.wbdata;
    ex_flush    = i.flush; ex_busy     = i.busy;
  endtask

  task automatic add(input string n, input in_t i, input exp_t e);
    vec_t v;
    v.name = n; v.i = i; v.e = e;
    vecs.push_back(v);
  endtask

  localparam in_t IDLE = '{1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0,
                           5'd0, 1'b0, 1'b0, 16'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0};

  in_t i_ld, i_use;

  initial begin
    // Reset state
    rst = 1'b0;
    drive(IDLE);
    #2;
    check("reset_valid", {31'b0, ex_valid}, 32'h0);
    check("reset_pc", ex_pc, 32'h0);
    check("reset_cnt", {30'b0, bubble_cnt}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    //   name             vld pc        rs1  u1 d1            rs2  u2 d2            imm           rd   rw mr ctrl      wbwr wbrd wbdata       fl bz
    //                    stall vld chk pc       op1           op2           imm           rd   rw mr ctrl      cnt
    add("capture",   '{1, 32'h100, 5'd1, 1, 32'h11,        5'd2, 1, 32'h22,     32'hFFFFFFF0, 5'd3, 1, 0, 16'h1234, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h100, 32'h11,        32'h22,        32'hFFFFFFF0, 5'd3, 1, 0, 16'h1234, 2'd0});
    add("bypass_rs1",'{1, 32'h104, 5'd5, 1, 32'h0,         5'd6, 1, 32'h66,     32'h4,        5'd8, 1, 0, 16'h0001, 1, 5'd5, 32'hDEADBEEF, 0, 0},
                     '{0, 1, 1, 32'h104, 32'hDEADBEEF,  32'h66,        32'h4,        5'd8, 1, 0, 16'h0001, 2'd0});
    add("bypass_x0", '{1, 32'h108, 5'd0, 1, 32'h0,         5'd0, 1, 32'h0,      32'h8,        5'd9, 1, 0, 16'h0002, 1, 5'd0, 32'hDEADBEEF, 0, 0},
                     '{0, 1, 1, 32'h108, 32'h0,         32'h0,         32'h8,        5'd9, 1, 0, 16'h0002, 2'd0});
    add("load_byp2", '{1, 32'h10C, 5'd5, 1, 32'h55,        5'd9, 1, 32'h99,     32'h10,       5'd7, 1, 1, 16'h8000, 1, 5'd9, 32'hCAFEF00D, 0, 0},
                     '{0, 1, 1, 32'h10C, 32'h55,        32'hCAFEF00D,  32'h10,       5'd7, 1, 1, 16'h8000, 2'd0});
    add("lu_bubble", '{1, 32'h110, 5'd2, 1, 32'h2,         5'd7, 1, 32'h77,     32'h0,        5'd10,1, 0, 16'h0004, 0, 5'd0, 32'h0,        0, 0},
                     '{1, 0, 0, 32'h0,   32'h0,         32'h0,         32'h0,        5'd0, 0, 0, 16'h0000, 2'd1});
    add("lu_resume", '{1, 32'h110, 5'd2, 1, 32'h2,         5'd7, 1, 32'h77,     32'h0,        5'd10,1, 0, 16'h0004, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h110, 32'h2,         32'h77,        32'h0,        5'd10,1, 0, 16'h0004, 2'd1});
    add("load2",     '{1, 32'h114, 5'd0, 0, 32'h0,         5'd0, 0, 32'h0,      32'h20,       5'd7, 1, 1, 16'h0100, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h114, 32'h0,         32'h0,         32'h20,       5'd7, 1, 1, 16'h0100, 2'd1});
    add("rs2_unused",'{1, 32'h118, 5'd3, 1, 32'h33,        5'd7, 0, 32'h7777,   32'h30,       5'd11,1, 0, 16'h0008, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h118, 32'h33,        32'h7777,      32'h30,       5'd11,1, 0, 16'h0008, 2'd1});
    for (int k = 0; k < 3; k++)
      add("busy_hold",'{1, 32'h11C, 5'd7, 1, 32'hAA,       5'd8, 1, 32'hBB,     32'h40,       5'd12,1, 1, 16'h0010, 0, 5'd0, 32'h0,        0, 1},
                     '{1, 1, 1, 32'h118, 32'h33,        32'h7777,      32'h30,       5'd11,1, 0, 16'h0008, 2'd1});
    add("busy_flush",'{1, 32'h11C, 5'd7, 1, 32'hAA,        5'd8, 1, 32'hBB,     32'h40,       5'd12,1, 1, 16'h0010, 0, 5'd0, 32'h0,        1, 1},
                     '{1, 0, 0, 32'h0,   32'h0,         32'h0,         32'h0,        5'd0, 0, 0, 16'h0000, 2'd1});
    add("id_invalid",'{0, 32'h200, 5'd1, 1, 32'h1,         5'd2, 1, 32'h2,      32'h3,        5'd13,1, 1, 16'hFFFF, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 0, 0, 32'h0,   32'h0,         32'h0,         32'h0,        5'd0, 0, 0, 16'h0000, 2'd1});
    add("load_rd4",  '{1, 32'h120, 5'd0, 0, 32'h0,         5'd0, 0, 32'h0,      32'h50,       5'd4, 1, 1, 16'h0020, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h120, 32'h0,         32'h0,         32'h50,       5'd4, 1, 1, 16'h0020, 2'd1});
    add("lu_flush",  '{1, 32'h124, 5'd4, 1, 32'h44,        5'd0, 0, 32'h0,      32'h60,       5'd5, 1, 0, 16'h0040, 0, 5'd0, 32'h0,        1, 0},
                     '{0, 0, 0, 32'h0,   32'h0,         32'h0,         32'h0,        5'd0, 0, 0, 16'h0000, 2'd1});
    add("load_rd0",  '{1, 32'h128, 5'd0, 0, 32'h0,         5'd0, 0, 32'h0,      32'h70,       5'd0, 1, 1, 16'h0080, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h128, 32'h0,         32'h0,         32'h70,       5'd0, 1, 1, 16'h0080, 2'd1});
    add("use_x0",    '{1, 32'h12C, 5'd0, 1, 32'h0,         5'd0, 1, 32'h0,      32'h80,       5'd6, 1, 0, 16'h0200, 0, 5'd0, 32'h0,        0, 0},
                     '{0, 1, 1, 32'h12C, 32'h0,         32'h0,         32'h80,       5'd6, 1, 0, 16'h0200, 2'd1});

    foreach (vecs[n]) begin
      drive(vecs[n].i);
      #1;
      check({vecs[n].name, ".stall_id"}, {31'b0, stall_id}, {31'b0, vecs[n].e.stall});
      @(posedge clk); #1;
      check({vecs[n].name, ".ex_valid"},  {31'b0, ex_valid},   {31'b0, vecs[n].e.vld});
      check({vecs[n].name, ".ex_rd_wr"},  {31'b0, ex_rd_wr},   {31'b0, vecs[n].e.rdwr});
      check({vecs[n].name, ".ex_mem_rd"}, {31'b0, ex_mem_rd},  {31'b0, vecs[n].e.memrd});
      check({vecs[n].name, ".ex_ctrl"},   {16'b0, ex_ctrl},    {16'b0, vecs[n].e.ctrl});
      check({vecs[n].name, ".bubble_cnt"},{30'b0, bubble_cnt}, {30'b0, vecs[n].e.cnt});
      if (vecs[n].e.chk) begin
        check({vecs[n].name, ".ex_pc"},       ex_pc,       vecs[n].e.pc);
        check({vecs[n].name, ".ex_rs1_data"}, ex_rs1_data, vecs[n].e.op1);
        check({vecs[n].name, ".ex_rs2_data"}, ex_rs2_data, vecs[n].e.op2);
        check({vecs[n].name, ".ex_imm"},      ex_imm,      vecs[n].e.imm);
        check({vecs[n].name, ".ex_rd"},       {27'b0, ex_rd}, {27'b0, vecs[n].e.rd});
      end
      $display("vec %0d %s: stall_id=%0b ex_valid=%0b ex_pc=%h cnt=%0d",
               n, vecs[n].name, stall_id, ex_valid, ex_pc, bubble_cnt);
    end

    // Asynchronous reset between edges: outputs clear without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("midrst.ex_valid",   {31'b0, ex_valid},   32'h0);
    check("midrst.ex_rd_wr",   {31'b0, ex_rd_wr},   32'h0);
    check("midrst.ex_ctrl",    {16'b0, ex_ctrl},    32'h0);
    check("midrst.bubble_cnt", {30'b0, bubble_cnt}, 32'h0);
    $display("mid-run reset: ex_valid=%0b ex_ctrl=%h cnt=%0d", ex_valid, ex_ctrl, bubble_cnt);
    drive(IDLE);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Counter saturation: five load/use pairs, each producing one bubble.
    i_ld  = IDLE;
    i_ld.vld = 1'b1; i_ld.rd = 5'd7; i_ld.rdwr = 1'b1; i_ld.memrd = 1'b1; i_ld.ctrl = 16'h0001;
    i_use = IDLE;
    i_use.vld = 1'b1; i_use.rs1 = 5'd7; i_use.u1 = 1'b1; i_use.rd = 5'd9; i_use.rdwr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_cnt;
      exp_cnt = (k < 3) ? 2'(k + 1) : 2'd3;
      drive(i_ld);
      @(posedge clk); #1;
      check("sat.load_mem_rd", {31'b0, ex_mem_rd}, 32'h1);
      drive(i_use);
      #1;
      check("sat.stall_id", {31'b0, stall_id}, 32'h1);
      @(posedge clk); #1;
      check("sat.ex_valid",   {31'b0, ex_valid},   32'h0);
      check("sat.bubble_cnt", {30'b0, bubble_cnt}, {30'b0, exp_cnt});
      $display("saturation hazard %0d: bubble_cnt=%0d", k + 1, bubble_cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
